// File: rtl/sum_display_driver.sv
// sum_display_driver
// Captures the upstream adder sum on a load strobe and splits it into
// tens/ones digits. The digits are time-multiplexed onto a 2-digit
// common-enable 7-segment display. Captures are counted with a
// saturating counter.
//
// Pipeline (edges counted from the load edge N):
//   N   : val, valid and capture_cnt update.
//   N+1 : tens/ones are derived from val.
//   N+2 : seg/an show the new digit if its slot is active.
//
// Optional build macro SUM_DISPLAY_LZ_BLANK_EN:
//   When defined, a leading zero in the tens slot is blanked (an=00, seg=00).
//   The slot timing does not change.
//   When undefined, the tens slot always shows enc(tens).
//
// Handshake: load is a plain strobe with no back-pressure. din is taken on
// every rising edge where load=1 and rst=0.
// dbg_scan_state exposes the scan FSM state (0=SHOW_ONES, 1=SHOW_TENS).
module sum_display_driver #(
  parameter int DATA_W      = 4,
  parameter int REFRESH_DIV = 4,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic [6:0]        seg,
  output logic [1:0]        an,
  output logic              valid,
  output logic [CNT_W-1:0]  capture_cnt,
  output logic              dbg_scan_state
);

  typedef enum logic {
    SHOW_ONES = 1'b0,
    SHOW_TENS = 1'b1
  } scan_state_e;

  localparam int RW = (REFRESH_DIV <= 2) ? 1 : $clog2(REFRESH_DIV);
  localparam logic [RW-1:0]    REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [DATA_W-1:0] val_q, val_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        tens_q, tens_d;
  logic [3:0]        ones_q, ones_d;
  logic [RW-1:0]     ref_q, ref_d;
  scan_state_e       state_q, state_d;
  logic [6:0]        seg_q, seg_d;
  logic [1:0]        an_q, an_d;
  logic [6:0]        val_ext;

  // Map a decimal digit to segments {g,f,e,d,c,b,a}. Non-decimal codes are blank.
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  endfunction

  // Capture stage: latch din on load, set valid and count the capture (saturating).
  always_comb begin
    val_d   = val_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (load) begin
      val_d   = din;
      valid_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Convert stage: split the captured value into decimal digits (max 63).
  always_comb begin
    val_ext = 7'(val_q);
    tens_d  = 3'(val_ext / 7'd10);
    ones_d  = 4'(val_ext % 7'd10);
  end

  // Scan next-state: the refresh counter and FSM run only once a value exists.
  // A load never restarts them.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    if (valid_q) begin
      if (ref_q == REF_LAST) begin
        ref_d   = '0;
        state_d = (state_q == SHOW_ONES) ? SHOW_TENS : SHOW_ONES;
      end else begin
        ref_d = ref_q + RW'(1);
      end
    end
  end

  // Scan output decode: one-hot digit enable plus the segments for that slot.
  always_comb begin
    seg_d = 7'h00;
    an_d  = 2'b00;
    if (valid_q) begin
      case (state_q)
        SHOW_ONES: begin
          an_d  = 2'b01;
          seg_d = enc(ones_q);
        end
        SHOW_TENS: begin
`ifdef SUM_DISPLAY_LZ_BLANK_EN
          if (tens_q != 3'd0) begin
            an_d  = 2'b10;
            seg_d = enc({1'b0, tens_q});
          end
`else
          an_d  = 2'b10;
          seg_d = enc({1'b0, tens_q});
`endif
        end
        default: begin
          an_d  = 2'b00;
          seg_d = 7'h00;
        end
      endcase
    end
  end

  // Scan state register: refresh counter and FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW_ONES;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
    end
  end

  // Datapath registers: capture, convert and output stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      seg_q   <= 7'h00;
      an_q    <= 2'b00;
    end else begin
      val_q   <= val_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg            = seg_q;
  assign an             = an_q;
  assign valid          = valid_q;
  assign capture_cnt    = cnt_q;
  assign dbg_scan_state = state_q;

endmodule

// File: tb/tb_sum_display_driver.sv
// Directed bench for sum_display_driver: default-width instance (dut) plus a
// DATA_W=5 instance (dut5) sharing clock and reset.
module tb_sum_display_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       load, load5;
  logic [3:0] din;
  logic [4:0] din5;
  logic [6:0] seg, seg5;
  logic [1:0] an, an5;
  logic       valid, valid5;
  logic [3:0] capture_cnt, capture_cnt5;
  logic       dbg, dbg5;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  sum_display_driver dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .seg(seg), .an(an),
    .valid(valid), .capture_cnt(capture_cnt), .dbg_scan_state(dbg)
  );

  sum_display_driver #(.DATA_W(5)) dut5 (
    .clk(clk), .rst(rst), .load(load5), .din(din5), .seg(seg5), .an(an5),
    .valid(valid5), .capture_cnt(capture_cnt5), .dbg_scan_state(dbg5)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; load5 = 1'b0; din = '0; din5 = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; din = 4'd5;
    step();
    total++;
    if ({an, seg, valid, capture_cnt} !== 14'd0) begin
      bad++;
      $display("FAIL reset_override got an=%b seg=%h valid=%b cnt=%0d want all 0", an, seg, valid, capture_cnt);
    end
    rst = 1'b0; load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if ({an, seg, valid, capture_cnt} !== 14'd0) begin
        bad++;
        $display("FAIL idle_blank cyc=%0d got an=%b seg=%h valid=%b cnt=%0d want all 0", i, an, seg, valid, capture_cnt);
      end
    end
  endtask

  task automatic test_load13();
    logic [8:0] exp;
    do_reset();
    din = 4'd13; load = 1'b1;
    step();
    load = 1'b0;
    total++;
    if ({valid, capture_cnt} !== 5'b1_0001) begin
      bad++;
      $display("FAIL l13_valid_cnt got valid=%b cnt=%0d want valid=1 cnt=1", valid, capture_cnt);
    end
    step();
    for (int k = 2; k <= 12; k++) begin
      step();
      exp = (((k - 1) / 4) % 2 == 0) ? {2'b01, 7'h4F} : {2'b10, 7'h06};
      total++;
      if ({an, seg} !== exp) begin
        bad++;
        $display("FAIL l13_scan k=%0d got an=%b seg=%h want an=%b seg=%h", k, an, seg, exp[8:7], exp[6:0]);
      end
    end
    total++;
    if (capture_cnt !== 4'd1) begin
      bad++;
      $display("FAIL l13_cnt_hold got %0d want 1", capture_cnt);
    end
  endtask

  task automatic test_leading_zero();
    logic [8:0] exp;
    do_reset();
    din = 4'd7; load = 1'b1;
    step();
    load = 1'b0;
    step();
    for (int k = 2; k <= 12; k++) begin
      step();
`ifdef SUM_DISPLAY_LZ_BLANK_EN
      exp = (((k - 1) / 4) % 2 == 0) ? {2'b01, 7'h07} : {2'b00, 7'h00};
`else
      exp = (((k - 1) / 4) % 2 == 0) ? {2'b01, 7'h07} : {2'b10, 7'h3F};
`endif
      total++;
      if ({an, seg} !== exp) begin
        bad++;
        $display("FAIL lz_scan k=%0d got an=%b seg=%h want an=%b seg=%h", k, an, seg, exp[8:7], exp[6:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    logic [3:0] exp_cnt;
    do_reset();
    load = 1'b1;
    for (int i = 0; i < 17; i++) begin
      din = 4'((i + 12) % 16);
      step();
      exp_cnt = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      total++;
      if (capture_cnt !== exp_cnt) begin
        bad++;
        $display("FAIL b2b_cnt i=%0d got %0d want %0d", i, capture_cnt, exp_cnt);
      end
    end
    load = 1'b0;
    // last load edge is k=16; value 12 visible from k=18
    step();
    for (int k = 18; k <= 26; k++) begin
      step();
      exp = (((k - 1) / 4) % 2 == 0) ? {2'b01, 7'h5B} : {2'b10, 7'h06};
      total++;
      if ({an, seg} !== exp) begin
        bad++;
        $display("FAIL b2b_scan k=%0d got an=%b seg=%h want an=%b seg=%h", k, an, seg, exp[8:7], exp[6:0]);
      end
    end
    total++;
    if (capture_cnt !== 4'd15) begin
      bad++;
      $display("FAIL b2b_cnt_sat got %0d want 15", capture_cnt);
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    din = 4'd9; load = 1'b1;
    step();
    load = 1'b0;
    repeat (5) step();
    total++;
    if (an !== 2'b01 && an !== 2'b10) begin
      bad++;
      $display("FAIL mid_active got an=%b want one-hot", an);
    end
    rst = 1'b1;
    step();
    total++;
    if ({an, seg, valid, capture_cnt} !== 14'd0) begin
      bad++;
      $display("FAIL mid_rst got an=%b seg=%h valid=%b cnt=%0d want all 0", an, seg, valid, capture_cnt);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if ({an, seg, valid, capture_cnt} !== 14'd0) begin
        bad++;
        $display("FAIL post_rst_blank cyc=%0d got an=%b seg=%h valid=%b cnt=%0d want all 0", i, an, seg, valid, capture_cnt);
      end
    end
  endtask

  task automatic test_load_in_tens_slot();
    logic [8:0] exp;
    do_reset();
    din5 = 5'd20; load5 = 1'b1;
    step();                       // k=0
    load5 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) begin
        din5 = 5'd31; load5 = 1'b1; // sampled at edge k=5, FSM in SHOW_TENS
      end
      step();
      load5 = 1'b0;
      if (k >= 2) begin
        if (k <= 6)
          exp = (((k - 1) / 4) % 2 == 0) ? {2'b01, 7'h3F} : {2'b10, 7'h5B};
        else
          exp = (((k - 1) / 4) % 2 == 0) ? {2'b01, 7'h06} : {2'b10, 7'h4F};
        total++;
        if ({an5, seg5} !== exp) begin
          bad++;
          $display("FAIL tens_slot_load k=%0d got an=%b seg=%h want an=%b seg=%h", k, an5, seg5, exp[8:7], exp[6:0]);
        end
      end
    end
    total++;
    if (capture_cnt5 !== 4'd2) begin
      bad++;
      $display("FAIL dw5_cnt got %0d want 2", capture_cnt5);
    end
  endtask

  // an must never drive both digits
  always @(negedge clk) begin
    if (an === 2'b11 || an5 === 2'b11) begin
      bad++;
      $display("FAIL an_onehot got an=%b an5=%b want never 11", an, an5);
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; load5 = 1'b0; din = '0; din5 = '0;
    test_reset();
    test_load13();
    test_leading_zero();
    test_back_to_back();
    test_reset_mid_scan();
    test_load_in_tens_slot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_display_driver.md
Name: sum_display_driver

Overview:
- Downstream consumer of the counter/adder result bus; captures the 4-bit sum on its load strobe.
- Converts the captured value to two decimal digits and time-multiplexes them onto a 2-digit common-enable 7-segment display.
- Also counts capture events for debug and readout.

Parameters:
- DATA_W, 4: width of din. Supported range 1..6, so the maximum value is 63 and always fits two digits.
- REFRESH_DIV, 4: clock cycles each digit slot is held before switching. Minimum 2.
- CNT_W, 4: width of the capture event counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- load  input  1  capture strobe; din is sampled on any edge where load=1.
- din  input  DATA_W  unsigned result value from the upstream adder.
- seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}; registered.
- an  output  2  digit enable, active-high one-hot; an[0]=ones, an[1]=tens; registered.
- valid  output  1  set once at least one capture has occurred since reset.
- capture_cnt  output  CNT_W  number of captures since reset, saturating.

Behaviour:
- Reset: on an edge with rst=1, all registers clear the same edge, overriding load.
  - Cleared registers: val, tens, ones, valid, capture_cnt, refresh counter, scan FSM.
  - Resulting outputs: seg=0, an=0, valid=0, capture_cnt=0, FSM=SHOW_ONES.
- Capture stage (cycle N): with load=1 and rst=0:
  - val<=din and valid<=1.
  - capture_cnt<=capture_cnt+1, saturating at 2^CNT_W-1 and never wrapping.
  - With load=0, val holds.
- Convert stage (cycle N+1): tens<=val/10, ones<=val%10, both 3/4-bit unsigned. Registered, so latency is 1 cycle after capture.
- Output stage (cycle N+2): seg/an are registered from FSM state plus tens/ones. A new value is visible 2 edges after the load edge if its slot is active.
- Scan FSM: states SHOW_ONES and SHOW_TENS.
  - While valid=0: FSM and refresh counter are held at reset values; an=0, seg=0.
  - While valid=1: refresh counter counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and the FSM toggles (ONES->TENS->ONES ...).
  - Output state lags the FSM by 1 cycle.
- Output encoding:
  - SHOW_ONES: an=2'b01, seg=enc(ones).
  - SHOW_TENS: an=2'b10, seg=enc(tens), subject to Optional Feature.
- enc (digit -> seg): 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F. Any other code gives 7'h00.
- Simultaneous events and boundaries:
  - load during an active scan updates digits but never restarts the refresh counter or FSM.
  - Back-to-back loads: each is captured; displayed digits follow the last value with 2-cycle latency.
  - din=0 displays ones=0 in the ones slot.
  - an is never 2'b11.

Optional Feature:
- Macro: SUM_DISPLAY_LZ_BLANK_EN.
- Defined: during SHOW_TENS with tens==0, an=2'b00 and seg=7'h00 (leading zero blanked); slot timing is unchanged.
- Undefined: the tens slot always shows enc(tens), so a leading zero is displayed as 7'h3F with an=2'b10.

Test Plan:
- Idle after reset, no load for 20 cycles -> an=0, seg=0, valid=0, capture_cnt=0 throughout.
- din=13, 1-cycle load -> valid=1 the next edge. Then alternating every 4 cycles: an=01/seg=7'h4F and an=10/seg=7'h06. capture_cnt=1.
- din=7, 1-cycle load -> ones slot an=01/seg=7'h07. Tens slot depends on the macro:
  - Macro defined: an=00/seg=00.
  - Macro undefined: an=10/seg=7'h3F.
- 17 consecutive load cycles with CNT_W=4 -> capture_cnt reaches 15 and stays at 15. The displayed value equals the last din.
- Load din=9, then rst=1 mid-scan for 1 cycle -> on that edge all outputs read 0 and valid=0. After rst drops, still blank until the next load.
- DATA_W=5, din=31 loaded during a SHOW_TENS slot -> scan phase is undisturbed. Tens shows 7'h4F and ones shows 7'h06 from 2 edges after load.
